// File: rtl/map_render_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : map_render_ctrl
// Description : Frame-level scheduler for the tile blitter. Walks the map
//               grid row by row, reads one tile id per cell from map RAM
//               (1-cycle read latency) and launches one start/done
//               handshaked blit per non-empty cell. Runs on the system clock.
// Ports       :
//   clk, rst          system clock, synchronous active-high reset
//   i_frame_start     single-cycle request to render one frame
//   o_busy            high while a frame is in progress
//   o_frame_done      single-cycle pulse after the last cell completes
//   o_map_rd_en       map RAM read strobe
//   o_map_x/o_map_y   grid cell being read or drawn
//   i_map_tile_id     map RAM read data (valid the cycle after o_map_rd_en)
//   o_tile_start      single-cycle pulse launching one blit
//   o_tile_addr       tile ROM base address of the current tile
//   o_tile_top/left   destination pixel position of the current tile
//   i_tile_done       single-cycle pulse from the blitter
// Revision    : 1.0 - initial release
// ============================================================================
module map_render_ctrl #(
  parameter int          GRID_W           = 11,
  parameter int          GRID_H           = 11,
  parameter int          TILE_PX_SHIFT    = 5,
  parameter int          TILE_WORDS_SHIFT = 10,
  parameter logic [18:0] EMPTY_ID         = 19'h7FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_start,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_map_rd_en,
  output logic [3:0]  o_map_x,
  output logic [3:0]  o_map_y,
  input  logic [18:0] i_map_tile_id,
  output logic        o_tile_start,
  output logic [18:0] o_tile_addr,
  output logic [9:0]  o_tile_top,
  output logic [9:0]  o_tile_left,
  input  logic        i_tile_done
);

  localparam logic [3:0] c_X_LAST = 4'(GRID_W - 1);
  localparam logic [3:0] c_Y_LAST = 4'(GRID_H - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_START     = 3'd3,
    S_WAIT_TILE = 3'd4,
    S_ADVANCE   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t      r_state;
  logic        r_pending;
  logic        r_busy;
  logic        r_frame_done;
  logic        r_map_rd_en;
  logic [3:0]  r_x;
  logic [3:0]  r_y;
  logic        r_tile_start;
  logic [18:0] r_tile_addr;
  logic [9:0]  r_tile_top;
  logic [9:0]  r_tile_left;

  // Zero-filled shifts; the address deliberately wraps to 19 bits.
  logic [18:0] w_tile_addr;
  logic [9:0]  w_tile_top;
  logic [9:0]  w_tile_left;

  assign w_tile_addr = i_map_tile_id << TILE_WORDS_SHIFT;
  assign w_tile_top  = 10'(r_y) << TILE_PX_SHIFT;
  assign w_tile_left = 10'(r_x) << TILE_PX_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pending    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_map_rd_en  <= 1'b0;
      r_x          <= 4'd0;
      r_y          <= 4'd0;
      r_tile_start <= 1'b0;
      r_tile_addr  <= 19'd0;
      r_tile_top   <= 10'd0;
      r_tile_left  <= 10'd0;
    end else begin
      // Requests arriving while a frame runs (including the DONE cycle)
      // collapse into a single queued frame.
      if (r_state != S_IDLE && i_frame_start) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_frame_start || r_pending) begin
            r_pending   <= 1'b0;
            r_x         <= 4'd0;
            r_y         <= 4'd0;
            r_busy      <= 1'b1;
            r_map_rd_en <= 1'b1;
            r_state     <= S_FETCH;
          end
        end

        S_FETCH: begin
          r_map_rd_en <= 1'b0;
          r_state     <= S_WAIT_DATA;
        end

        S_WAIT_DATA: begin
          if (i_map_tile_id == EMPTY_ID) begin
            r_state <= S_ADVANCE;
          end else begin
            r_tile_addr  <= w_tile_addr;
            r_tile_top   <= w_tile_top;
            r_tile_left  <= w_tile_left;
            r_tile_start <= 1'b1;
            r_state      <= S_START;
          end
        end

        S_START: begin
          r_tile_start <= 1'b0;
          r_state      <= S_WAIT_TILE;
        end

        S_WAIT_TILE: begin
          if (i_tile_done) begin
            r_state <= S_ADVANCE;
          end
        end

        S_ADVANCE: begin
          if (r_x != c_X_LAST) begin
            r_x         <= r_x + 4'd1;
            r_map_rd_en <= 1'b1;
            r_state     <= S_FETCH;
          end else begin
            r_x <= 4'd0;
            if (r_y != c_Y_LAST) begin
              r_y         <= r_y + 4'd1;
              r_map_rd_en <= 1'b1;
              r_state     <= S_FETCH;
            end else begin
              // busy drops in the same cycle frame_done is presented
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_frame_done <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_map_rd_en  = r_map_rd_en;
  assign o_map_x      = r_x;
  assign o_map_y      = r_y;
  assign o_tile_start = r_tile_start;
  assign o_tile_addr  = r_tile_addr;
  assign o_tile_top   = r_tile_top;
  assign o_tile_left  = r_tile_left;

endmodule
`default_nettype wire

// File: tb/tb_map_render_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_map_render_ctrl
// Description : Scoreboard bench for map_render_ctrl. Stimulus pushes the
//               expected blit/frame_done sequence of each frame computed from
//               the map contents; a monitor pops and compares whenever the
//               DUT pulses tile_start or frame_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_render_ctrl;

  localparam int GW    = 11;
  localparam int GH    = 11;
  localparam int EMPTY = 'h7FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_frame_start = 1'b0;
  logic [18:0] i_map_tile_id = 19'd0;
  logic        i_tile_done;
  logic        auto_done = 1'b0;
  logic        man_done  = 1'b0;

  logic        o_busy, o_frame_done, o_map_rd_en, o_tile_start;
  logic [3:0]  o_map_x, o_map_y;
  logic [18:0] o_tile_addr;
  logic [9:0]  o_tile_top, o_tile_left;

  assign i_tile_done = auto_done | man_done;

  always #5 clk = ~clk;

  map_render_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_frame_start (i_frame_start),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_map_rd_en   (o_map_rd_en),
    .o_map_x       (o_map_x),
    .o_map_y       (o_map_y),
    .i_map_tile_id (i_map_tile_id),
    .o_tile_start  (o_tile_start),
    .o_tile_addr   (o_tile_addr),
    .o_tile_top    (o_tile_top),
    .o_tile_left   (o_tile_left),
    .i_tile_done   (i_tile_done)
  );

  typedef struct {
    bit is_done;
    int addr;
    int top;
    int left;
    int x;
    int y;
  } exp_t;

  exp_t exp_q[$];
  int   map_mem[GH][GW];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   n_done_seen = 0;
  bit   blit_auto  = 1'b0;

  task automatic chk(input bit ok, input string name, input string detail);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference model: raster order, empty cells skipped, then one frame_done.
  function automatic void push_frame();
    exp_t e;
    for (int y = 0; y < GH; y++) begin
      for (int x = 0; x < GW; x++) begin
        if (map_mem[y][x] != EMPTY) begin
          e.is_done = 1'b0;
          e.addr    = (map_mem[y][x] * 1024) % (1 << 19);
          e.top     = y * 32;
          e.left    = x * 32;
          e.x       = x;
          e.y       = y;
          exp_q.push_back(e);
        end
      end
    end
    e = '{is_done: 1'b1, addr: 0, top: 0, left: 0, x: 0, y: 0};
    exp_q.push_back(e);
  endfunction

  // kind 0: id=x+y, 1: random with ~25% empty, 2: all empty,
  // 3: first three cells of row 0 empty, rest random non-empty
  function automatic void fill_map(input int kind);
    for (int y = 0; y < GH; y++) begin
      for (int x = 0; x < GW; x++) begin
        case (kind)
          0: map_mem[y][x] = x + y;
          1: map_mem[y][x] = ($urandom_range(0, 3) == 0) ? EMPTY
                             : int'($urandom_range(0, 'h7FFFE));
          2: map_mem[y][x] = EMPTY;
          default: map_mem[y][x] = (y == 0 && x < 3) ? EMPTY
                                   : int'($urandom_range(0, 'h7FFFE));
        endcase
      end
    end
  endfunction

  function automatic bit all_zero();
    return !o_busy && !o_frame_done && !o_map_rd_en && !o_tile_start &&
           o_map_x == 4'd0 && o_map_y == 4'd0 && o_tile_addr == 19'd0 &&
           o_tile_top == 10'd0 && o_tile_left == 10'd0;
  endfunction

  // Map RAM: garbage right after the read strobe, real data one cycle later.
  initial begin : map_ram
    forever begin
      @(negedge clk);
      if (o_map_rd_en) begin
        int rx, ry;
        rx = int'(o_map_x);
        ry = int'(o_map_y);
        i_map_tile_id = 19'h2AAAA;
        @(negedge clk);
        if (rx < GW && ry < GH) i_map_tile_id = 19'(map_mem[ry][rx]);
        else i_map_tile_id = 19'h15555;
      end
    end
  end

  // Blitter model: tile_done 1..5 cycles after tile_start.
  initial begin : blitter
    int d;
    forever begin
      @(negedge clk);
      if (blit_auto && o_tile_start) begin
        d = int'($urandom_range(1, 5));
        repeat (d) @(negedge clk);
        auto_done = 1'b1;
        @(negedge clk);
        auto_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (o_tile_start || o_frame_done)) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_event", $sformatf(
              "got tile_start=%0b frame_done=%0b x=%0d y=%0d, required no event",
              o_tile_start, o_frame_done, o_map_x, o_map_y));
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            chk(o_frame_done && !o_tile_start && !o_busy, "frame_done", $sformatf(
                "got frame_done=%0b tile_start=%0b busy=%0b, required 1 0 0",
                o_frame_done, o_tile_start, o_busy));
          end else begin
            chk(o_tile_start && !o_frame_done && o_busy &&
                o_tile_addr == 19'(e.addr) && o_tile_top == 10'(e.top) &&
                o_tile_left == 10'(e.left) && o_map_x == 4'(e.x) &&
                o_map_y == 4'(e.y), "blit", $sformatf(
                "got start=%0b done=%0b addr=%h top=%0d left=%0d x=%0d y=%0d, required start=1 addr=%h top=%0d left=%0d x=%0d y=%0d",
                o_tile_start, o_frame_done, o_tile_addr, o_tile_top, o_tile_left,
                o_map_x, o_map_y, e.addr, e.top, e.left, e.x, e.y));
          end
        end
        if (o_frame_done) n_done_seen++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || o_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(c < budget, name, $sformatf(
        "got busy=%0b pending_events=%0d after %0d cycles, required idle with none",
        o_busy, exp_q.size(), c));
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin : stim
    int d0, c;
    bit bad;

    repeat (3) tick();
    chk(all_zero(), "reset_state", $sformatf(
        "got busy=%0b rd_en=%0b start=%0b x=%0d y=%0d addr=%h, required all 0",
        o_busy, o_map_rd_en, o_tile_start, o_map_x, o_map_y, o_tile_addr));
    rst = 1'b0;
    tick();

    // Timing frame, id = x+y
    fill_map(0);
    push_frame();
    blit_auto = 1'b0;
    pulse_start();
    chk(o_map_rd_en && o_busy && o_map_x == 0 && o_map_y == 0, "rd_en_cycle1",
        $sformatf("got rd_en=%0b busy=%0b x=%0d y=%0d, required 1 1 0 0",
                  o_map_rd_en, o_busy, o_map_x, o_map_y));
    tick();
    chk(!o_map_rd_en && !o_tile_start, "cycle2_quiet",
        $sformatf("got rd_en=%0b start=%0b, required 0 0", o_map_rd_en, o_tile_start));
    tick();
    chk(o_tile_start, "tile_start_cycle3",
        $sformatf("got start=%0b, required 1", o_tile_start));
    repeat (6) tick();
    chk(!o_map_rd_en && !o_tile_start && o_busy, "wait_tile_hold",
        $sformatf("got rd_en=%0b start=%0b busy=%0b, required 0 0 1",
                  o_map_rd_en, o_tile_start, o_busy));
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk(!o_map_rd_en, "advance_cycle",
        $sformatf("got rd_en=%0b, required 0", o_map_rd_en));
    tick();
    chk(o_map_rd_en && o_map_x == 1 && o_map_y == 0, "rd_en_after_done",
        $sformatf("got rd_en=%0b x=%0d y=%0d, required 1 1 0",
                  o_map_rd_en, o_map_x, o_map_y));
    blit_auto = 1'b1;
    wait_idle(5000, "frame_xy_complete");

    // Random frames
    for (int f = 0; f < 4; f++) begin
      fill_map(1);
      push_frame();
      pulse_start();
      wait_idle(5000, "frame_random_complete");
    end

    // All-empty frame
    fill_map(2);
    push_frame();
    d0 = n_done_seen;
    pulse_start();
    wait_idle(2000, "frame_empty_complete");
    chk(n_done_seen == d0 + 1, "empty_frame_done",
        $sformatf("got %0d frame_done, required 1", n_done_seen - d0));

    // Three requests during a frame -> exactly one extra frame
    fill_map(1);
    push_frame();
    push_frame();
    d0 = n_done_seen;
    pulse_start();
    repeat (30) tick();
    pulse_start();
    repeat (5) tick();
    pulse_start();
    repeat (5) tick();
    pulse_start();
    c = 0;
    while (!o_frame_done && c < 5000) begin
      tick();
      c++;
    end
    chk(c < 5000, "pending_first_done",
        $sformatf("got no frame_done in %0d cycles, required one", c));
    tick();
    chk(!o_map_rd_en && !o_busy, "pending_idle_gap",
        $sformatf("got rd_en=%0b busy=%0b, required 0 0", o_map_rd_en, o_busy));
    tick();
    chk(o_map_rd_en && o_busy && o_map_x == 0 && o_map_y == 0, "pending_restart",
        $sformatf("got rd_en=%0b busy=%0b x=%0d y=%0d, required 1 1 0 0",
                  o_map_rd_en, o_busy, o_map_x, o_map_y));
    wait_idle(5000, "pending_frame_complete");
    repeat (20) tick();
    chk(!o_busy && n_done_seen == d0 + 2, "pending_one_extra",
        $sformatf("got busy=%0b frame_done count=%0d, required 0 and 2",
                  o_busy, n_done_seen - d0));

    // Request during the DONE cycle
    fill_map(1);
    push_frame();
    push_frame();
    d0 = n_done_seen;
    pulse_start();
    c = 0;
    while (!o_frame_done && c < 5000) begin
      tick();
      c++;
    end
    pulse_start();
    wait_idle(5000, "done_cycle_request");
    chk(n_done_seen == d0 + 2, "done_cycle_pending",
        $sformatf("got frame_done count=%0d, required 2", n_done_seen - d0));

    // tile_done in IDLE
    blit_auto = 1'b0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (o_busy || o_tile_start || o_map_rd_en) bad = 1'b1;
    end
    chk(!bad, "done_in_idle", $sformatf("got activity=%0b, required 0", bad));

    // tile_done in FETCH
    fill_map(0);
    push_frame();
    pulse_start();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    blit_auto = 1'b1;
    chk(!o_map_rd_en && !o_tile_start && o_busy, "done_in_fetch_wait",
        $sformatf("got rd_en=%0b start=%0b busy=%0b, required 0 0 1",
                  o_map_rd_en, o_tile_start, o_busy));
    tick();
    chk(o_tile_start, "done_in_fetch_start",
        $sformatf("got start=%0b, required 1", o_tile_start));
    wait_idle(5000, "done_in_fetch_frame");

    // Reset mid-row while waiting on the blitter
    blit_auto = 1'b0;
    fill_map(3);
    push_frame();
    pulse_start();
    c = 0;
    while (!o_tile_start && c < 100) begin
      tick();
      c++;
    end
    chk(c < 100 && o_map_x == 3 && o_map_y == 0, "reset_setup",
        $sformatf("got start=%0b x=%0d y=%0d, required 1 3 0",
                  o_tile_start, o_map_x, o_map_y));
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk(all_zero(), "reset_mid_frame", $sformatf(
        "got busy=%0b rd_en=%0b start=%0b x=%0d y=%0d addr=%h top=%0d left=%0d, required all 0",
        o_busy, o_map_rd_en, o_tile_start, o_map_x, o_map_y, o_tile_addr,
        o_tile_top, o_tile_left));
    exp_q.delete();
    rst = 1'b0;
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      tick();
      if (o_busy || o_tile_start || o_map_rd_en) bad = 1'b1;
    end
    chk(!bad, "late_done_ignored", $sformatf("got activity=%0b, required 0", bad));
    fill_map(1);
    push_frame();
    blit_auto = 1'b1;
    pulse_start();
    chk(o_map_rd_en && o_map_x == 0 && o_map_y == 0, "restart_after_reset",
        $sformatf("got rd_en=%0b x=%0d y=%0d, required 1 0 0",
                  o_map_rd_en, o_map_x, o_map_y));
    wait_idle(5000, "restart_frame_complete");

    chk(exp_q.size() == 0, "queue_drained",
        $sformatf("got %0d outstanding events, required 0", exp_q.size()));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/map_render_ctrl.md
Name: map_render_ctrl

Overview:
- Frame-level scheduler for the tile blitter (render_tile).
- Walks the map grid cell by cell and reads each tile id from map RAM (1-cycle read latency).
- Issues one start/done-handshaked blit per cell with tile_addr/top/left; skips empty cells.
- Replaces the free-running divided-clock grid scan; runs entirely on the system clock.

Parameters:
- GRID_W, 11, cells per row (x runs 0..GRID_W-1).
- GRID_H, 11, rows per frame (y runs 0..GRID_H-1).
- TILE_PX_SHIFT, 5, log2 of tile edge in pixels (top = y<<5, left = x<<5).
- TILE_WORDS_SHIFT, 10, log2 of words per tile in tile ROM (tile_addr = id<<10).
- EMPTY_ID, 19'h7FFFF, tile id meaning "nothing to draw".

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  single-cycle request to render one full frame.
- busy  out  1  high from the first cycle after an accepted frame_start until frame_done.
- frame_done  out  1  single-cycle pulse after the last cell completes.
- map_rd_en  out  1  map RAM read strobe.
- map_x  out  4  grid column being read or drawn.
- map_y  out  4  grid row being read or drawn.
- map_tile_id  in  19  map RAM data, valid the cycle after map_rd_en.
- tile_start  out  1  single-cycle pulse launching one tile blit.
- tile_addr  out  19  tile ROM base address, {id<<TILE_WORDS_SHIFT}[18:0].
- tile_top  out  10  destination y pixel, map_y<<TILE_PX_SHIFT.
- tile_left  out  10  destination x pixel, map_x<<TILE_PX_SHIFT.
- tile_done  in  1  single-cycle pulse from the blitter when a tile finishes.

Behaviour:
- Reset (rst=1 at a clk edge) forces state IDLE and clears every output: busy, frame_done, map_rd_en, tile_start, map_x, map_y, tile_addr, tile_top, tile_left, and the pending flag.
- Reset mid-frame aborts immediately. An outstanding tile_done arriving after reset is ignored.
- States:
  - IDLE: frame_start or pending -> FETCH with x=y=0, busy=1, pending cleared.
  - FETCH: map_rd_en=1 for exactly one cycle -> WAIT_DATA.
  - WAIT_DATA: capture map_tile_id.
    - If id==EMPTY_ID -> ADVANCE (no blit).
    - Otherwise register tile_addr/top/left -> START.
  - START: tile_start=1 for one cycle -> WAIT_TILE.
  - WAIT_TILE: hold until tile_done=1 -> ADVANCE.
  - ADVANCE:
    - x<GRID_W-1: x+1 -> FETCH.
    - Else x=0. If y<GRID_H-1: y+1 -> FETCH. Else -> DONE.
  - DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- Latency: frame_start accepted at cycle 0 gives map_rd_en at cycle 1 and tile_start at cycle 3. tile_done at cycle n gives the next map_rd_en at cycle n+2.
- Output stability: tile_addr/top/left and map_x/map_y stay stable from START through the tile_done cycle.
- Arithmetic: shifts are zero-filled; tile_addr is truncated to 19 bits. For the default grid, the max top/left is 320, which fits in 10 bits.
- tile_done outside WAIT_TILE is ignored.
- frame_start while busy sets pending (one deep; further requests are dropped). From IDLE, a pending request starts the next frame one cycle after frame_done.
- frame_start in the same cycle as DONE also sets pending.
- A frame where every cell is EMPTY_ID still produces frame_done, with zero tile_start pulses.

Test Plan:
- Default grid, map id = x+y, blitter returns tile_done 4 cycles after each tile_start -> 121 tile_start pulses and exactly one frame_done. The last blit has top=320, left=320, tile_addr=20<<10=0x5000.
- GRID_W=2, GRID_H=2, ids {3, EMPTY_ID, 7, 1} -> 3 blits with (addr, top, left) = (0x0C00,0,0), (0x1C00,32,0), (0x0400,32,32). The cell (1,0) is skipped.
- frame_start pulsed 3 times during a frame -> exactly one extra frame. Its map_rd_en starts 2 cycles after the first frame_done; total frame_done count is 2.
- rst asserted while in WAIT_TILE mid-row -> next cycle all outputs 0, state IDLE. A late tile_done produces no tile_start. A new frame_start restarts at x=y=0.
- tile_done pulsed in IDLE and in FETCH -> no state change, no tile_start.
- Timing check: frame_start at cycle 0 -> map_rd_en exactly at cycle 1, tile_start exactly at cycle 3. tile_done at cycle 10 -> next map_rd_en at cycle 12.
